// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core control blocks.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ERROR = 2'd2
  } hc_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // count register: clear, saturating increment, or hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Load-use / branch / memory-wait hazard sequencer for the 5-stage pipeline,
// with launch gating, memory-timeout trap and saturating performance counters.
module hazard_controller
  import mips_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  cnt_clr_i,
  input  logic                  IDEX_memread_i,
  input  logic [REG_ADDR_W-1:0] IDEX_Rt_i,
  input  logic [REG_ADDR_W-1:0] IFID_Rs_i,
  input  logic [REG_ADDR_W-1:0] IFID_Rt_i,
  input  logic                  IFID_useRt_i,
  input  logic                  branch_taken_i,
  input  logic                  MEM_req_i,
  input  logic                  MEM_ack_i,
  output logic                  PC_write_o,
  output logic                  IFID_write_o,
  output logic                  IDEX_bubble_o,
  output logic                  IFID_flush_o,
  output logic                  pipe_freeze_o,
  output logic                  error_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o,
  output logic [CNT_W-1:0]      wait_cnt_o
);

  // The wait-run counter only ever needs to reach MEM_TIMEOUT-1.
  localparam int WT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WT_W-1:0] WT_LAST = WT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

  hc_state_t       state_r, state_next;
  logic [WT_W-1:0] wait_run_r;
  logic            mem_wait, load_use, timeout_hit;
  logic            stall_inc, flush_inc, wait_inc;

  assign mem_wait = MEM_req_i & ~MEM_ack_i;
  assign load_use = IDEX_memread_i
                  & (IDEX_Rt_i != REG_ADDR_W'(REG_ZERO))
                  & ((IDEX_Rt_i == IFID_Rs_i) | (IFID_useRt_i & (IDEX_Rt_i == IFID_Rt_i)));
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_run_r == WT_LAST);

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // consecutive memory-wait cycles in RUN; any non-wait cycle restarts it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_run_r <= '0;
    end else if ((state_r == RUN) && mem_wait) begin
      if (wait_run_r != '1) begin
        wait_run_r <= wait_run_r + WT_W'(1);
      end else begin
        wait_run_r <= wait_run_r;
      end
    end else begin
      wait_run_r <= '0;
    end
  end

  // next state and priority-ordered pipeline controls
  always_comb begin
    state_next    = state_r;
    pipe_freeze_o = 1'b1;
    PC_write_o    = 1'b0;
    IFID_write_o  = 1'b0;
    IDEX_bubble_o = 1'b0;
    IFID_flush_o  = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    wait_inc      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        pipe_freeze_o = 1'b0;
        if (mem_wait) begin
          pipe_freeze_o = 1'b1;
          wait_inc      = 1'b1;
          if (timeout_hit) begin
            state_next = ERROR;
          end else begin
            state_next = RUN;
          end
        end else if (load_use) begin
          // a coincident taken branch is not flushed: its operands are stale
          IDEX_bubble_o = 1'b1;
          stall_inc     = 1'b1;
        end else if (branch_taken_i) begin
          PC_write_o   = 1'b1;
          IFID_write_o = 1'b1;
          IFID_flush_o = 1'b1;
          flush_inc    = 1'b1;
        end else begin
          PC_write_o   = 1'b1;
          IFID_write_o = 1'b1;
        end
      end
      ERROR: begin
        state_next = ERROR;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign error_o = (state_r == ERROR);

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (stall_inc),
    .clr   (cnt_clr_i),
    .count (stall_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (flush_inc),
    .clr   (cnt_clr_i),
    .count (flush_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_W)) u_wait_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (wait_inc),
    .clr   (cnt_clr_i),
    .count (wait_cnt_o)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed and randomized checks of hazard_controller against a behavioural model.
module tb_hazard_controller;

  localparam int RW   = 5;
  localparam int CW   = 3;
  localparam int TMO  = 4;
  localparam int SAT  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0, start_i = 1'b0, cnt_clr_i = 1'b0;
  logic          IDEX_memread_i = 1'b0, IFID_useRt_i = 1'b0, branch_taken_i = 1'b0;
  logic          MEM_req_i = 1'b0, MEM_ack_i = 1'b0;
  logic [RW-1:0] IDEX_Rt_i = '0, IFID_Rs_i = '0, IFID_Rt_i = '0;
  logic          PC_write_o, IFID_write_o, IDEX_bubble_o, IFID_flush_o, pipe_freeze_o, error_o;
  logic [CW-1:0] stall_cnt_o, flush_cnt_o, wait_cnt_o;

  hazard_controller #(.REG_ADDR_W(RW), .CNT_W(CW), .MEM_TIMEOUT(TMO)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .cnt_clr_i      (cnt_clr_i),
    .IDEX_memread_i (IDEX_memread_i),
    .IDEX_Rt_i      (IDEX_Rt_i),
    .IFID_Rs_i      (IFID_Rs_i),
    .IFID_Rt_i      (IFID_Rt_i),
    .IFID_useRt_i   (IFID_useRt_i),
    .branch_taken_i (branch_taken_i),
    .MEM_req_i      (MEM_req_i),
    .MEM_ack_i      (MEM_ack_i),
    .PC_write_o     (PC_write_o),
    .IFID_write_o   (IFID_write_o),
    .IDEX_bubble_o  (IDEX_bubble_o),
    .IFID_flush_o   (IFID_flush_o),
    .pipe_freeze_o  (pipe_freeze_o),
    .error_o        (error_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o),
    .wait_cnt_o     (wait_cnt_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // behavioural model: running / trapped flags, run length of waits, counters
  bit m_run, m_err;
  int m_wrun, m_stall, m_flush, m_wait;
  int kind;  // 0 frozen-idle/error, 1 memory wait, 2 load-use, 3 taken branch, 4 normal
  bit e_pc, e_ifid, e_bub, e_fl, e_frz;

  function automatic int sat_inc(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  task automatic model_reset();
    m_run = 0; m_err = 0; m_wrun = 0; m_stall = 0; m_flush = 0; m_wait = 0;
  endtask

  task automatic model_outputs();
    bit lu;
    lu = IDEX_memread_i && (IDEX_Rt_i != 0) &&
         ((IDEX_Rt_i == IFID_Rs_i) || (IFID_useRt_i && (IDEX_Rt_i == IFID_Rt_i)));
    if (!m_run)                        kind = 0;
    else if (MEM_req_i && !MEM_ack_i)  kind = 1;
    else if (lu)                       kind = 2;
    else if (branch_taken_i)           kind = 3;
    else                               kind = 4;
    e_frz  = (kind <= 1);
    e_pc   = (kind >= 3);
    e_ifid = (kind >= 3);
    e_bub  = (kind == 2);
    e_fl   = (kind == 3);
  endtask

  task automatic model_edge();
    if (rst_i) begin
      model_reset();
    end else begin
      if (cnt_clr_i) begin
        m_stall = 0; m_flush = 0; m_wait = 0;
      end else begin
        if (kind == 1) m_wait  = sat_inc(m_wait);
        if (kind == 2) m_stall = sat_inc(m_stall);
        if (kind == 3) m_flush = sat_inc(m_flush);
      end
      if (m_run) begin
        if (kind == 1) begin
          m_wrun++;
          if (m_wrun == TMO) begin
            m_run = 0; m_err = 1; m_wrun = 0;
          end
        end else begin
          m_wrun = 0;
        end
      end else if (!m_err && start_i) begin
        m_run = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // caller sets inputs at posedge+1; outputs are checked at posedge+4, then the clock advances
  task automatic step(input string tag);
    #3;
    if (rst_i) model_reset();
    model_outputs();
    chk({tag, ".PC_write"},   32'(PC_write_o),    32'(e_pc));
    chk({tag, ".IFID_write"}, 32'(IFID_write_o),  32'(e_ifid));
    chk({tag, ".bubble"},     32'(IDEX_bubble_o), 32'(e_bub));
    chk({tag, ".flush"},      32'(IFID_flush_o),  32'(e_fl));
    chk({tag, ".freeze"},     32'(pipe_freeze_o), 32'(e_frz));
    chk({tag, ".error"},      32'(error_o),       32'(m_err));
    chk({tag, ".stall_cnt"},  32'(stall_cnt_o),   32'(m_stall));
    chk({tag, ".flush_cnt"},  32'(flush_cnt_o),   32'(m_flush));
    chk({tag, ".wait_cnt"},   32'(wait_cnt_o),    32'(m_wait));
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    start_i = 1'b0; cnt_clr_i = 1'b0; IDEX_memread_i = 1'b0; IFID_useRt_i = 1'b0;
    branch_taken_i = 1'b0; MEM_req_i = 1'b0; MEM_ack_i = 1'b0;
    IDEX_Rt_i = '0; IFID_Rs_i = '0; IFID_Rt_i = '0;
  endtask

  task automatic set_lu(input int rt, input int rs, input int irt, input bit use_rt);
    IDEX_memread_i = 1'b1; IDEX_Rt_i = RW'(rt); IFID_Rs_i = RW'(rs);
    IFID_Rt_i = RW'(irt); IFID_useRt_i = use_rt;
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;

    // reset and launch
    quiet(); rst_i = 1'b1; step("reset");
    rst_i = 1'b0; step("idle");
    start_i = 1'b1; step("start");
    start_i = 1'b0; step("run_first");

    // load-use detection
    set_lu(8, 8, 0, 1'b0); step("lu_rs");
    set_lu(0, 0, 0, 1'b1); step("lu_r0");
    set_lu(8, 3, 8, 1'b0); step("lu_rt_unused");
    set_lu(8, 3, 8, 1'b1); step("lu_rt_used");
    quiet(); step("normal");

    // branch, and branch masked by load-use
    branch_taken_i = 1'b1; step("branch");
    set_lu(9, 9, 0, 1'b0); step("branch_lu");
    quiet(); step("after_branch");

    // three wait cycles with a load-use pending, then ack
    MEM_req_i = 1'b1; set_lu(5, 5, 0, 1'b0);
    for (int i = 0; i < 3; i++) step("mem_wait");
    MEM_ack_i = 1'b1; step("mem_ack");
    quiet(); step("post_wait");

    // saturation then clear with simultaneous stall
    set_lu(4, 4, 0, 1'b0);
    for (int i = 0; i < 10; i++) step("stall_sat");
    cnt_clr_i = 1'b1; step("clr_with_stall");
    cnt_clr_i = 1'b0; quiet(); step("after_clr");

    // asynchronous reset mid-run
    rst_i = 1'b1; step("rst_mid_run");
    rst_i = 1'b0; start_i = 1'b1; step("relaunch");
    start_i = 1'b0; step("relaunch_run");

    // timeout: request never acknowledged
    MEM_req_i = 1'b1;
    for (int i = 0; i < 5; i++) step("timeout");
    MEM_ack_i = 1'b1; start_i = 1'b1; step("error_ack_ignored");
    quiet(); step("error_hold");
    rst_i = 1'b1; step("rst_from_error");
    rst_i = 1'b0; start_i = 1'b1; step("launch_after_error");

    // randomized traffic with occasional long wait bursts and resets
    for (int n = 0; n < 3000; n++) begin
      rst_i          = ($urandom_range(199) == 0);
      start_i        = ($urandom_range(3) == 0);
      cnt_clr_i      = ($urandom_range(49) == 0);
      IDEX_memread_i = $urandom_range(1);
      IDEX_Rt_i      = RW'($urandom_range(3));
      IFID_Rs_i      = RW'($urandom_range(3));
      IFID_Rt_i      = RW'($urandom_range(3));
      IFID_useRt_i   = $urandom_range(1);
      branch_taken_i = ($urandom_range(2) == 0);
      if ((n / 40) % 4 == 3) begin
        MEM_req_i = 1'b1;
        MEM_ack_i = ($urandom_range(5) == 0);
      end else begin
        MEM_req_i = ($urandom_range(3) == 0);
        MEM_ack_i = $urandom_range(1);
      end
      step("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard and stall sequencer for the 5-stage MIPS core. It sits beside the EX-stage forwarding unit and covers the hazards that forwarding cannot resolve. It generates PC/IF-ID write enables, ID/EX bubble insertion, IF/ID flush on taken branches, and a global freeze while the data memory has not acknowledged. It also holds the core idle until launch, traps a hung memory access, and keeps saturating performance counters.

## Interface
- `REG_ADDR_W`, 5, register-specifier width
- `CNT_W`, 16, width of each performance counter
- `MEM_TIMEOUT`, 64, consecutive unacknowledged memory-wait cycles before trap; 0 disables the trap

Ports:
- `clk_i`  in  1  core clock; one clock, all state on the rising edge
- `rst_i`  in  1  reset, asynchronous, active-high
- `start_i`  in  1  launch; sampled only in IDLE
- `cnt_clr_i`  in  1  synchronous clear of all three counters
- `IDEX_memread_i`  in  1  instruction in EX is a load
- `IDEX_Rt_i`  in  `REG_ADDR_W`  load destination in EX
- `IFID_Rs_i`, `IFID_Rt_i`  in  `REG_ADDR_W`  source registers of the instruction in ID
- `IFID_useRt_i`  in  1  instruction in ID reads Rt as a source
- `branch_taken_i`  in  1  branch resolved taken in ID
- `MEM_req_i`, `MEM_ack_i`  in  1  MEM-stage data-memory request and completion
- `PC_write_o`, `IFID_write_o`  out  1  PC and IF/ID register enables
- `IDEX_bubble_o`  out  1  zero ID/EX control bits
- `IFID_flush_o`  out  1  replace IF/ID with a NOP
- `pipe_freeze_o`  out  1  hold every pipeline register, including EX/MEM and MEM/WB
- `error_o`  out  1  memory-timeout trap, sticky
- `stall_cnt_o`, `flush_cnt_o`, `wait_cnt_o`  out  `CNT_W`  load-use bubbles, flushes, and memory-wait cycles

## Operation
- States: IDLE, RUN, ERROR. Reset enters IDLE.
- IDLE:
  - Outputs: freeze=1, PC_write=0, IFID_write=0, bubble=0, flush=0.
  - Moves to RUN on the edge where start_i=1.
- RUN: start_i is ignored. Outputs are combinational from state and inputs, evaluated in this priority order:
  1. Memory wait, `wait = MEM_req_i & ~MEM_ack_i`: freeze=1, PC_write=0, IFID_write=0, bubble=0, flush=0.
  2. Load-use, `lu = IDEX_memread_i & IDEX_Rt_i!=0 & (IDEX_Rt_i==IFID_Rs_i | (IFID_useRt_i & IDEX_Rt_i==IFID_Rt_i))`: PC_write=0, IFID_write=0, bubble=1, flush=0.
  3. Taken branch: PC_write=1, IFID_write=1, flush=1.
  4. Otherwise: PC_write=1, IFID_write=1, all other outputs 0.
- A taken branch coinciding with load-use is not flushed, because its operands are stale. The stalled branch re-resolves on the next cycle.
- Wait counter: counts consecutive RUN cycles with `wait`=1 and returns to 0 on any cycle without `wait`. If `MEM_TIMEOUT`≠0 and a wait cycle occurs while the counter equals `MEM_TIMEOUT-1`, the next state is ERROR.
- ERROR:
  - Outputs: same as IDLE, plus error_o=1.
  - Leaves only on reset; MEM_ack_i is ignored.
- Counters:
  - Increment only in RUN: stall_cnt on priority-2 cycles, flush_cnt on priority-3 cycles, wait_cnt on priority-1 cycles.
  - Saturate at all-ones, with no wrap.
  - cnt_clr_i overrides an increment in the same cycle.

## Timing
- Control outputs have zero latency, combinational from inputs in RUN. State, the wait counter and the performance counters update on the rising clock edge.
- Reset values, applied asynchronously on rst_i:
  - freeze=1, PC_write=0, IFID_write=0, bubble=0, flush=0, error=0.
  - All counters and the wait counter are 0; state is IDLE.
- First RUN cycle is the cycle after start_i is sampled high.
- A load-use bubble lasts exactly one cycle: once the load advances, IDEX_memread_i drops.
- Memory wait and freeze release in the same cycle MEM_ack_i rises.
- Reset mid-wait or in ERROR aborts immediately, with no pending state retained.

## Structure
- `mips_pkg` holds the `hc_state_t` enum (IDLE/RUN/ERROR) and the `REG_ZERO` constant.
- Sub-module `sat_counter`, instanced three times, with parameters width, inc, clr and a saturating output.
- Next-state and output logic stay in `hazard_controller`.

## Test plan
- **Reset/launch:** assert rst_i mid-RUN → freeze=1, PC_write=0, all counters 0. Pulse start_i → RUN next cycle, PC_write=1.
- **Load-use:** IDEX_memread=1, IDEX_Rt=8, IFID_Rs=8 → PC_write=0, IFID_write=0, bubble=1, stall_cnt 0→1. With IDEX_Rt=0, or IFID_Rt=8 and useRt=0 → no stall.
- **Branch:** branch_taken=1 → flush=1, PC_write=1, flush_cnt+1. Same cycle with a load-use match → flush=0, bubble=1, flush_cnt unchanged.
- **Memory wait:** MEM_req=1, ack=0 for 3 cycles then ack=1 → freeze=1 for exactly 3 cycles, wait_cnt=3, released in the ack cycle, load-use suppressed during the freeze.
- **Timeout:** MEM_TIMEOUT=4, req held without ack → ERROR after the 4th wait cycle, error_o=1 and freeze persist. A later ack is ignored; rst_i clears.
- **Saturation/clear:** CNT_W=2, 5 load-use cycles → stall_cnt=3. cnt_clr_i with a simultaneous stall → 0.
